pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the in-order RISC-V core; successor to the fixed 5-stage hazard/flush logic.
- Keeps a per-stage scoreboard from EX to WB (valid, rd, regwrite, memread) and detects RAW hazards against the instruction in decode.
- Drives PC/IF_ID write enables, IF flush and ID/EX bubble from that scoreboard and from a branch/jump redirect resolved at a configurable stage.
- Provides retire, stall and flush performance counters; supports forwarding and no-forwarding modes.

Parameters:
STAGES, 5, pipeline depth; stage 0=IF, 1=ID, 2=EX, STAGES-1=WB; legal 4..8
REG_AW, 5, register address width
RESOLVE_STAGE, 2, stage at which redirect is asserted; legal 2..STAGES-2
FORWARD_EN, 1, 1=ALU results forwarded (only load-use stalls); 0=no forwarding (any RAW stalls until producer is in WB)
FWD_STAGE, 4, earliest stage whose load result can be forwarded into EX; legal 3..STAGES-1
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a real instruction
id_rs1  in  REG_AW  decode source 1
id_rs2  in  REG_AW  decode source 2
id_rs1_used  in  1  rs1 is read by the decode instruction
id_rs2_used  in  1  rs2 is read by the decode instruction
id_rd  in  REG_AW  decode destination
id_regwrite  in  1  decode instruction writes rd
id_memread  in  1  decode instruction is a load
redirect  in  1  branch taken or jump, resolved at RESOLVE_STAGE
pc_write  out  1  PC update enable
ifid_write  out  1  IF_ID register write enable
if_flush  out  1  IF_ID and decode contents discarded
idex_bubble  out  1  control bits zeroed into ID_EX
stage_valid  out  STAGES-2  valid bits of scoreboard stages 2..STAGES-1 (bit 0 = EX)
retire_valid  out  1  valid instruction in WB this cycle
retire_count  out  CNT_W  retired instructions, saturating
stall_count  out  CNT_W  stall cycles, saturating
flush_count  out  CNT_W  redirects, saturating

Behaviour:
- Reset (async, rst_n=0): all scoreboard entries invalid; all counters 0. With inputs idle after reset: pc_write=1, ifid_write=1, if_flush=0, idex_bubble=0.
- Scoreboard: entry[s] for s=2..STAGES-1. Each clock edge: entry[s] <= entry[s-1] for s>=3; entry[2] <= decode fields, gated valid = id_valid & ~stall & ~redirect.
- Producer match at stage s: entry valid & regwrite & rd!=0 & ((rs1_used & rd==rs1) | (rs2_used & rd==rs2)). A match with id_valid=0 is ignored.
- Stall, FORWARD_EN=1: match at any s with memread=1 and s<=FWD_STAGE-2. With defaults, only a load in EX stalls (1 cycle).
- Stall, FORWARD_EN=0: any match at s in 2..STAGES-2. The regfile is write-first in WB.
- All hazard outputs are combinational from the registered scoreboard plus current inputs (same-cycle).
- Stall, no redirect: pc_write=0, ifid_write=0, idex_bubble=1, if_flush=0.
- Redirect: pc_write=1, ifid_write=1, if_flush=1, idex_bubble=1.
  - Redirect has priority over stall; a stall that coincides with a redirect is not counted.
  - Entries shifting into stages 3..RESOLVE_STAGE become invalid (younger instructions killed). The redirecting instruction itself advances normally.
- Otherwise: pc_write=1, ifid_write=1, if_flush=0, idex_bubble=0.
- retire_valid = entry[STAGES-1].valid.
- Counters: each increments by 1 per qualifying cycle and holds at all-ones. Updates are registered, so the new value is visible the cycle after the event.
- Reset mid-stall or mid-flush: all state is cleared immediately; a stall never persists across reset.

Test Plan:
1. Defaults; lw x5 issued, next cycle decode add x6,x5,x1 -> exactly 1 cycle pc_write=0/idex_bubble=1 while load in EX; stall_count=1; no stall if one independent instruction sits between them.
2. Load to rd=x0 followed by a consumer reading x0 -> no stall; rs2_used=0 with rs2 matching -> no stall.
3. FORWARD_EN=0; add x3 then sub x4,x3,x3 -> 2 stall cycles, consumer enters EX when producer reaches WB; stall_count=2.
4. redirect=1 in the same cycle as a load-use stall -> if_flush=1, pc_write=1, idex_bubble=1; stall_count unchanged, flush_count=1. With RESOLVE_STAGE=3, the entry entering stage 3 is invalid.
5. Stream 20 valid instructions, STAGES=6 -> retire_valid high 20 cycles, retire_count=20. CNT_W=4 with 20 retires -> retire_count holds at 15.
6. Assert rst_n=0 mid-stall -> stage_valid=0, counters=0, pc_write=1 within the same cycle; after release, normal issue resumes.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EX..WB scoreboard, RAW/load-use stall detection,
// redirect flushing and saturating retire/stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int STAGES        = 5,
  parameter int REG_AW        = 5,
  parameter int RESOLVE_STAGE = 2,
  parameter int FORWARD_EN    = 1,
  parameter int FWD_STAGE     = 4,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              redirect,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              if_flush,
  output logic              idex_bubble,
  output logic [STAGES-3:0] stage_valid,
  output logic              retire_valid,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic [STAGES-1:2]             r_valid;
  logic [STAGES-1:2]             r_regwrite;
  logic [STAGES-1:2]             r_memread;
  logic [STAGES-1:2][REG_AW-1:0] r_rd;
  logic [CNT_W-1:0]              r_retire_cnt;
  logic [CNT_W-1:0]              r_stall_cnt;
  logic [CNT_W-1:0]              r_flush_cnt;

  logic [STAGES-1:2] w_match;
  logic [STAGES-1:2] w_elig;
  logic [STAGES-1:3] w_kill;
  logic              w_hazard;
  logic              w_stall;

  // Per-stage producer match and whether a match at that depth must stall.
  for (genvar s = 2; s < STAGES; s++) begin : g_stage
    assign w_match[s] = r_valid[s] & r_regwrite[s] & (r_rd[s] != '0) &
                        ((id_rs1_used & (r_rd[s] == id_rs1)) |
                         (id_rs2_used & (r_rd[s] == id_rs2)));
    if (FORWARD_EN != 0) begin : g_fwd
      localparam bit LoadWindow = (s <= FWD_STAGE - 2);
      assign w_elig[s] = LoadWindow & r_memread[s];
    end else begin : g_nofwd
      localparam bit RawWindow = (s <= STAGES - 2);
      assign w_elig[s] = RawWindow;
    end
  end

  // Stages 3..RESOLVE_STAGE hold instructions younger than the redirecting one.
  for (genvar s = 3; s < STAGES; s++) begin : g_kill
    localparam bit Younger = (s <= RESOLVE_STAGE);
    assign w_kill[s] = Younger;
  end

  assign w_hazard = id_valid & (|(w_match & w_elig));
  assign w_stall  = w_hazard & ~redirect;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    if_flush    = 1'b0;
    idex_bubble = 1'b0;
    if (redirect) begin
      if_flush    = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_regwrite <= '0;
      r_memread  <= '0;
      r_rd       <= '0;
    end else begin
      r_valid[2]    <= id_valid & ~w_hazard & ~redirect;
      r_regwrite[2] <= id_regwrite;
      r_memread[2]  <= id_memread;
      r_rd[2]       <= id_rd;
      r_valid[STAGES-1:3]    <= r_valid[STAGES-2:2] & ~({(STAGES-3){redirect}} & w_kill);
      r_regwrite[STAGES-1:3] <= r_regwrite[STAGES-2:2];
      r_memread[STAGES-1:3]  <= r_memread[STAGES-2:2];
      r_rd[STAGES-1:3]       <= r_rd[STAGES-2:2];
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (r_valid[STAGES-1] && (r_retire_cnt != '1))
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stage_valid  = r_valid;
  assign retire_valid = r_valid[STAGES-1];
  assign retire_count = r_retire_cnt;
  assign stall_count  = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations share one decode stream and
// are compared every cycle against an in-flight instruction list model.
module tb_pipe_hazard_ctrl;

  // Config A = defaults, B = no forwarding with 4-bit counters, C = 6 stages.
  localparam int CfgStages[3] = '{5, 5, 6};
  localparam int CfgRes[3]    = '{2, 2, 3};
  localparam int CfgFwd[3]    = '{1, 0, 1};
  localparam int CfgFwdSt[3]  = '{4, 4, 5};
  localparam int CfgCw[3]     = '{32, 4, 32};

  logic clk = 1'b0;
  logic rst_n;
  logic idValid, rs1Used, rs2Used, idRegwrite, idMemread, redirect;
  logic [4:0] idRs1, idRs2, idRd;

  logic aPc, aIfid, aFlush, aBub, aRv;
  logic [2:0] aSv;
  logic [31:0] aRc, aSc, aFc;
  logic bPc, bIfid, bFlush, bBub, bRv;
  logic [2:0] bSv;
  logic [3:0] bRc, bSc, bFc;
  logic cPc, cIfid, cFlush, cBub, cRv;
  logic [3:0] cSv;
  logic [31:0] cRc, cSc, cFc;

  int tests = 0;
  int fails = 0;

  bit mValid[3][8];
  bit mRw[3][8];
  bit mMr[3][8];
  int mRd[3][8];
  longint mRet[3], mStl[3], mFl[3];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.STAGES(5), .REG_AW(5), .RESOLVE_STAGE(2), .FORWARD_EN(1),
                     .FWD_STAGE(4), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_rs1_used(rs1Used), .id_rs2_used(rs2Used), .id_rd(idRd),
    .id_regwrite(idRegwrite), .id_memread(idMemread), .redirect(redirect),
    .pc_write(aPc), .ifid_write(aIfid), .if_flush(aFlush), .idex_bubble(aBub),
    .stage_valid(aSv), .retire_valid(aRv), .retire_count(aRc),
    .stall_count(aSc), .flush_count(aFc));

  pipe_hazard_ctrl #(.STAGES(5), .REG_AW(5), .RESOLVE_STAGE(2), .FORWARD_EN(0),
                     .FWD_STAGE(4), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_rs1_used(rs1Used), .id_rs2_used(rs2Used), .id_rd(idRd),
    .id_regwrite(idRegwrite), .id_memread(idMemread), .redirect(redirect),
    .pc_write(bPc), .ifid_write(bIfid), .if_flush(bFlush), .idex_bubble(bBub),
    .stage_valid(bSv), .retire_valid(bRv), .retire_count(bRc),
    .stall_count(bSc), .flush_count(bFc));

  pipe_hazard_ctrl #(.STAGES(6), .REG_AW(5), .RESOLVE_STAGE(3), .FORWARD_EN(1),
                     .FWD_STAGE(5), .CNT_W(32)) u_c (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_rs1_used(rs1Used), .id_rs2_used(rs2Used), .id_rd(idRd),
    .id_regwrite(idRegwrite), .id_memread(idMemread), .redirect(redirect),
    .pc_write(cPc), .ifid_write(cIfid), .if_flush(cFlush), .idex_bubble(cBub),
    .stage_valid(cSv), .retire_valid(cRv), .retire_count(cRc),
    .stall_count(cSc), .flush_count(cFc));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A consumer must wait until its producer's value can reach it: with forwarding,
  // only a load still short of FWD_STAGE next cycle; without, anything not yet in WB.
  function automatic bit modelHazard(input int k);
    bit h = 1'b0;
    if (!idValid) return 1'b0;
    for (int s = 2; s < CfgStages[k]; s++) begin
      bit reads = (rs1Used && (mRd[k][s] == int'(idRs1))) || (rs2Used && (mRd[k][s] == int'(idRs2)));
      if (mValid[k][s] && mRw[k][s] && (mRd[k][s] != 0) && reads) begin
        if (CfgFwd[k] != 0) begin
          if (mMr[k][s] && (s + 1 < CfgFwdSt[k])) h = 1'b1;
        end else if (s < CfgStages[k] - 1) begin
          h = 1'b1;
        end
      end
    end
    return h;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 8; s++) begin
        mValid[k][s] = 1'b0; mRw[k][s] = 1'b0; mMr[k][s] = 1'b0; mRd[k][s] = 0;
      end
      mRet[k] = 0; mStl[k] = 0; mFl[k] = 0;
    end
  endtask

  task automatic modelCheck();
    string nm[3] = '{"A", "B", "C"};
    for (int k = 0; k < 3; k++) begin
      bit hz = modelHazard(k);
      logic [31:0] sv = '0;
      logic oPc, oIfid, oFlush, oBub, oRv;
      logic [31:0] oSv, oRc, oSc, oFc;
      for (int s = 2; s < CfgStages[k]; s++) sv[s-2] = mValid[k][s];
      case (k)
        0: begin oPc = aPc; oIfid = aIfid; oFlush = aFlush; oBub = aBub; oRv = aRv;
                 oSv = 32'(aSv); oRc = aRc; oSc = aSc; oFc = aFc; end
        1: begin oPc = bPc; oIfid = bIfid; oFlush = bFlush; oBub = bBub; oRv = bRv;
                 oSv = 32'(bSv); oRc = 32'(bRc); oSc = 32'(bSc); oFc = 32'(bFc); end
        default: begin oPc = cPc; oIfid = cIfid; oFlush = cFlush; oBub = cBub; oRv = cRv;
                 oSv = 32'(cSv); oRc = cRc; oSc = cSc; oFc = cFc; end
      endcase
      checkOutput({nm[k], ".pc_write"}, 32'(oPc), 32'(redirect || !hz));
      checkOutput({nm[k], ".ifid_write"}, 32'(oIfid), 32'(redirect || !hz));
      checkOutput({nm[k], ".if_flush"}, 32'(oFlush), 32'(redirect));
      checkOutput({nm[k], ".idex_bubble"}, 32'(oBub), 32'(redirect || hz));
      checkOutput({nm[k], ".stage_valid"}, oSv, sv);
      checkOutput({nm[k], ".retire_valid"}, 32'(oRv), 32'(mValid[k][CfgStages[k]-1]));
      checkOutput({nm[k], ".retire_count"}, oRc, 32'(mRet[k]));
      checkOutput({nm[k], ".stall_count"}, oSc, 32'(mStl[k]));
      checkOutput({nm[k], ".flush_count"}, oFc, 32'(mFl[k]));
    end
  endtask

  task automatic modelAdvance();
    for (int k = 0; k < 3; k++) begin
      bit hz = modelHazard(k);
      int st = CfgStages[k];
      longint maxv = (longint'(1) << CfgCw[k]) - 1;
      if (mValid[k][st-1] && mRet[k] < maxv) mRet[k]++;
      if (hz && !redirect && mStl[k] < maxv) mStl[k]++;
      if (redirect && mFl[k] < maxv) mFl[k]++;
      for (int s = st - 1; s >= 3; s--) begin
        mValid[k][s] = mValid[k][s-1] && !(redirect && s <= CfgRes[k]);
        mRw[k][s] = mRw[k][s-1]; mMr[k][s] = mMr[k][s-1]; mRd[k][s] = mRd[k][s-1];
      end
      mValid[k][2] = idValid && !hz && !redirect;
      mRw[k][2] = idRegwrite; mMr[k][2] = idMemread; mRd[k][2] = int'(idRd);
    end
  endtask

  task automatic setInputs(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                           input int rd, input bit rw, input bit mr, input bit redir);
    idValid = v; idRs1 = 5'(rs1); rs1Used = u1; idRs2 = 5'(rs2); rs2Used = u2;
    idRd = 5'(rd); idRegwrite = rw; idMemread = mr; redirect = redir;
  endtask

  task automatic applyStimulus(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                               input int rd, input bit rw, input bit mr, input bit redir);
    setInputs(v, rs1, u1, rs2, u2, rd, rw, mr, redir);
    #3;
    modelCheck();
  endtask

  task automatic tick();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #1;
    modelCheck();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int retireHigh;
    rst_n = 1'b0;
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #1;
    modelCheck();
    checkOutput("reset.pc_write", 32'(aPc), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use: exactly one stall cycle with defaults.
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkOutput("lu.A.pc_write", 32'(aPc), 32'd0);
    checkOutput("lu.A.bubble", 32'(aBub), 32'd1);
    tick();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkOutput("lu.A.pc_write2", 32'(aPc), 32'd1);
    tick();
    idleCycles(4);
    checkOutput("lu.A.stall_count", aSc, 32'd1);
    checkOutput("lu.B.stall_count", 32'(bSc), 32'd2);
    checkOutput("lu.C.stall_count", cSc, 32'd2);

    // Independent instruction between load and consumer.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 0); tick();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkOutput("gap.A.pc_write", 32'(aPc), 32'd1);
    tick();
    idleCycles(3);
    checkOutput("gap.A.stall_count", aSc, 32'd0);

    // x0 destination and unused rs2 never stall.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    applyStimulus(1, 0, 1, 0, 1, 6, 1, 0, 0);
    checkOutput("x0.A.bubble", 32'(aBub), 32'd0);
    checkOutput("x0.B.bubble", 32'(bBub), 32'd0);
    tick();
    idleCycles(4);
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    applyStimulus(1, 1, 1, 5, 0, 6, 1, 0, 0);
    checkOutput("rs2u.A.bubble", 32'(aBub), 32'd0);
    checkOutput("rs2u.B.bubble", 32'(bBub), 32'd0);
    checkOutput("rs2u.C.bubble", 32'(cBub), 32'd0);
    tick();
    idleCycles(3);
    checkOutput("x0.A.stall_count", aSc, 32'd0);

    // No forwarding: consumer waits until producer is in WB.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    applyStimulus(1, 3, 1, 3, 1, 4, 1, 0, 0);
    checkOutput("nofwd.B.pc1", 32'(bPc), 32'd0);
    tick();
    applyStimulus(1, 3, 1, 3, 1, 4, 1, 0, 0);
    checkOutput("nofwd.B.pc2", 32'(bPc), 32'd0);
    tick();
    applyStimulus(1, 3, 1, 3, 1, 4, 1, 0, 0);
    checkOutput("nofwd.B.pc3", 32'(bPc), 32'd1);
    checkOutput("nofwd.B.retire_valid", 32'(bRv), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("nofwd.B.stage_valid", 32'(bSv), 32'd1);
    tick();
    idleCycles(3);
    checkOutput("nofwd.B.stall_count", 32'(bSc), 32'd2);

    // Redirect coinciding with a load-use stall.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 1);
    checkOutput("redir.A.if_flush", 32'(aFlush), 32'd1);
    checkOutput("redir.A.pc_write", 32'(aPc), 32'd1);
    checkOutput("redir.A.bubble", 32'(aBub), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("redir.A.stage_valid", 32'(aSv), 32'h2);
    checkOutput("redir.C.stage_valid", 32'(cSv), 32'h0);
    tick();
    idleCycles(3);
    checkOutput("redir.A.stall_count", aSc, 32'd0);
    checkOutput("redir.A.flush_count", aFc, 32'd1);
    checkOutput("redir.C.flush_count", cFc, 32'd1);

    // 20 independent instructions; B's 4-bit counter saturates at 15.
    doReset();
    retireHigh = 0;
    for (int i = 0; i < 28; i++) begin
      if (i < 20) applyStimulus(1, 0, 0, 0, 0, (i % 7) + 1, 1, 0, 0);
      else applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (cRv) retireHigh++;
      tick();
    end
    checkOutput("stream.C.retire_cycles", 32'(retireHigh), 32'd20);
    checkOutput("stream.A.retire_count", aRc, 32'd20);
    checkOutput("stream.B.retire_count", 32'(bRc), 32'd15);
    checkOutput("stream.C.retire_count", cRc, 32'd20);

    // Asynchronous reset while a stall is being signalled.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 0, 0, i + 1, 1, 0, 0); tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkOutput("rst.A.stalling", 32'(aPc), 32'd0);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst.A.stage_valid", 32'(aSv), 32'd0);
    checkOutput("rst.A.pc_write", 32'(aPc), 32'd1);
    checkOutput("rst.A.retire_count", aRc, 32'd0);
    checkOutput("rst.C.stage_valid", 32'(cSv), 32'd0);
    modelCheck();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0); tick();
    idleCycles(5);
    checkOutput("rst.A.retire_after", aRc, 32'd1);

    // Randomised traffic over a small register range to provoke hazards.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, int'($urandom % 4), 1'($urandom), int'($urandom % 4),
                    1'($urandom), int'($urandom % 4), 1'($urandom), ($urandom % 3) == 0,
                    ($urandom % 8) == 0);
      tick();
    end
    idleCycles(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
